// File: rtl/cell_scan_controller.sv
// Frame sequencer for the combinational CellProcessor: gathers each pixel's 3x3
// neighbourhood (plane A, plus plane B for binary ops), issues one instruction, writes the result.
package cell_scan_pkg;
  typedef logic [7:0] pixel_t;
  typedef logic [7:0] user_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_AVG
  } opcode_t;
  typedef struct packed {
    pixel_t [2:0][2:0] pixelMatrix;
  } cell_t;
  typedef struct packed {
    opcode_t opcode;
    cell_t   cellA;
    cell_t   cellB;
    user_t   userInputA;
  } instruction_t;
endpackage

module cell_scan_controller
  import cell_scan_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = $clog2(2*IMG_W*IMG_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  opcode_t             cfg_opcode,
  input  user_t               cfg_user,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  pixel_t              rd_data,
  output instruction_t        IW,
  input  pixel_t              result,
  output logic                wr_en,
  output logic [ADDR_W-2:0]   wr_addr,
  output pixel_t              wr_data
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW:0] X_MAX = (XW+1)'(IMG_W-1);
  localparam logic [YW:0] Y_MAX = (YW+1)'(IMG_H-1);
  localparam logic [ADDR_W-1:0] PLANE_OFS = ADDR_W'(IMG_W*IMG_H);
  localparam logic [ADDR_W-1:0] RW = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-2:0] WW = (ADDR_W-1)'(IMG_W);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_ISSUE, S_DONE} state_t;
  state_t state, state_nx;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [4:0]    k, rd_k_q, k_last;
  logic          rd_vld_q;
  opcode_t       op_q;
  user_t         user_q;
  cell_t         cell_a, cell_b;
  instruction_t  iw_hold, iw_live;
  logic          is_bin, last_px;

  // Neighbourhood slot k maps to (row,col) within its plane; slots 9..17 are plane B.
  function automatic logic [3:0] rc_of(input logic [4:0] kk);
    logic [3:0] j;
    j = (kk >= 5'd9) ? 4'(kk - 5'd9) : kk[3:0];
    case (j)
      4'd0: rc_of = 4'b00_00;
      4'd1: rc_of = 4'b00_01;
      4'd2: rc_of = 4'b00_10;
      4'd3: rc_of = 4'b01_00;
      4'd4: rc_of = 4'b01_01;
      4'd5: rc_of = 4'b01_10;
      4'd6: rc_of = 4'b10_00;
      4'd7: rc_of = 4'b10_01;
      default: rc_of = 4'b10_10;
    endcase
  endfunction

  logic [1:0]    row, col, cap_row, cap_col;
  logic [XW:0]   xt, xm1;
  logic [YW:0]   yt, ym1;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic [ADDR_W-1:0] addr_calc;

  always_comb begin
    {row, col}         = rc_of(k);
    {cap_row, cap_col} = rc_of(rd_k_q);
    xt  = (XW+1)'(x) + (XW+1)'(col);
    yt  = (YW+1)'(y) + (YW+1)'(row);
    xm1 = xt - (XW+1)'(1);
    ym1 = yt - (YW+1)'(1);
    // Clamp to the frame so border pixels replicate the edge.
    if (xt == '0)         xs = '0;
    else if (xm1 > X_MAX) xs = X_MAX[XW-1:0];
    else                  xs = xm1[XW-1:0];
    if (yt == '0)         ys = '0;
    else if (ym1 > Y_MAX) ys = Y_MAX[YW-1:0];
    else                  ys = ym1[YW-1:0];
    addr_calc = ((k >= 5'd9) ? PLANE_OFS : '0) + ADDR_W'(ys) * RW + ADDR_W'(xs);
  end

  assign is_bin  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign k_last  = is_bin ? 5'd17 : 5'd8;
  assign last_px = (x == X_MAX[XW-1:0]) && (y == Y_MAX[YW-1:0]);

  always_comb begin
    iw_live            = '0;
    iw_live.opcode     = op_q;
    iw_live.cellA      = cell_a;
    iw_live.cellB      = is_bin ? cell_b : '0;
    iw_live.userInputA = user_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: if (k == k_last) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_ISSUE;
      S_ISSUE: state_nx = last_px ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    rd_en   = (state == S_FETCH);
    rd_addr = rd_en ? addr_calc : '0;
    wr_en   = (state == S_ISSUE);
    wr_addr = wr_en ? ((ADDR_W-1)'(y) * WW + (ADDR_W-1)'(x)) : '0;
    wr_data = wr_en ? result : '0;
    IW      = wr_en ? iw_live : iw_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      k        <= '0;
      rd_k_q   <= '0;
      rd_vld_q <= 1'b0;
      op_q     <= OP_NOP;
      user_q   <= '0;
      cell_a   <= '0;
      cell_b   <= '0;
      iw_hold  <= '0;
    end else begin
      rd_vld_q <= rd_en;
      rd_k_q   <= k;
      // Memory data lands one cycle after its read; DRAIN exists to catch the final slot.
      if (rd_vld_q) begin
        if (rd_k_q >= 5'd9) cell_b.pixelMatrix[cap_row][cap_col] <= rd_data;
        else                cell_a.pixelMatrix[cap_row][cap_col] <= rd_data;
      end
      case (state)
        S_IDLE: if (start) begin
          op_q   <= cfg_opcode;
          user_q <= cfg_user;
          x      <= '0;
          y      <= '0;
          k      <= '0;
        end
        S_FETCH: k <= (k == k_last) ? 5'd0 : k + 5'd1;
        S_ISSUE: begin
          iw_hold <= iw_live;
          if (x == X_MAX[XW-1:0]) begin
            x <= '0;
            y <= (y == Y_MAX[YW-1:0]) ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cell_scan_controller.sv
// Scoreboard bench for cell_scan_controller on a 4x4 frame with a behavioural
// frame memory and CellProcessor.
module tb_cell_scan_controller;
  import cell_scan_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int AW = 5;

  logic         clk = 0;
  logic         rst = 1;
  logic         start = 0;
  opcode_t      cfg_opcode = OP_NOP;
  user_t        cfg_user = '0;
  logic         busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr;
  logic [AW-2:0] wr_addr;
  pixel_t       rd_data, result, wr_data;
  instruction_t IW;

  int test_cnt = 0;
  int fail_cnt = 0;
  int reads_px = 0;
  int wr_count = 0;
  pixel_t mem [0:31];
  int pix00 [9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
  logic [16:0] exp_q[$];  // {wr_addr, wr_data, reads for this pixel}
  logic [4:0]  rd_q[$];

  cell_scan_controller #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_opcode(cfg_opcode), .cfg_user(cfg_user),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .IW(IW), .result(result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic pixel_t cp_model(input instruction_t iw);
    int s;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) s += int'(iw.cellA.pixelMatrix[r][c]);
    case (iw.opcode)
      OP_ADD:  cp_model = iw.cellA.pixelMatrix[1][1] + iw.cellB.pixelMatrix[1][1];
      OP_SUB:  cp_model = iw.cellA.pixelMatrix[1][1] - iw.cellB.pixelMatrix[1][1];
      OP_ADDI: cp_model = iw.cellA.pixelMatrix[1][1] + iw.userInputA;
      OP_SUBI: cp_model = iw.cellA.pixelMatrix[1][1] - iw.userInputA;
      OP_AVG:  cp_model = pixel_t'(s / 9);
      default: cp_model = iw.cellA.pixelMatrix[1][1];
    endcase
  endfunction
  assign result = cp_model(IW);

  function automatic int clampi(input int v, input int mx);
    clampi = (v < 0) ? 0 : (v > mx) ? mx : v;
  endfunction

  function automatic pixel_t pix(input int p, input int x, input int y);
    pix = mem[p*16 + clampi(y, H-1)*W + clampi(x, W-1)];
  endfunction

  // Golden result straight from the image planes, independent of cell assembly.
  function automatic pixel_t golden(input opcode_t op, input int x, input int y, input pixel_t u);
    int s;
    s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) s += int'(pix(0, x+dx, y+dy));
    case (op)
      OP_ADD:  golden = pix(0, x, y) + pix(1, x, y);
      OP_SUB:  golden = pix(0, x, y) - pix(1, x, y);
      OP_ADDI: golden = pix(0, x, y) + u;
      OP_SUBI: golden = pix(0, x, y) - u;
      OP_AVG:  golden = pixel_t'(s / 9);
      default: golden = pix(0, x, y);
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a read or a write.
  always @(negedge clk) begin
    logic [16:0] e;
    logic [4:0]  a;
    if (rst) begin
      exp_q.delete();
      rd_q.delete();
      reads_px = 0;
    end else begin
      if (rd_en && wr_en) check("rd_wr_overlap", 1, 0);
      if (rd_en) begin
        reads_px++;
        if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_addr), 32'hFFFF);
        else begin
          a = rd_q.pop_front();
          check("rd_addr", 32'(rd_addr), 32'(a));
        end
      end
      if (wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) check("wr_unexpected", 32'(wr_addr), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[16:13]));
          check("wr_data", 32'(wr_data), 32'(e[12:5]));
          check("px_reads", 32'(reads_px), 32'(e[4:0]));
        end
        reads_px = 0;
      end
    end
  end

  task automatic push_frame(input opcode_t op, input pixel_t u);
    int n;
    n = (op == OP_ADD || op == OP_SUB) ? 18 : 9;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        for (int k = 0; k < n; k++) begin
          int j, p, a;
          j = k % 9;
          p = k / 9;
          if (x == 0 && y == 0 && p == 0) a = pix00[j];
          else a = p*16 + clampi(y + j/3 - 1, H-1)*W + clampi(x + j%3 - 1, W-1);
          rd_q.push_back(5'(a));
        end
        exp_q.push_back({4'(y*W + x), golden(op, x, y, u), 5'(n)});
      end
  endtask

  task automatic wait_done(input string nm, input int lat);
    int cyc;
    cyc = 1;
    while (!done && cyc < 1000) begin
      cycle();
      cyc++;
    end
    check({nm, "_latency"}, 32'(cyc), 32'(lat));
    cycle();
    check({nm, "_done_pulse"}, 32'(done), 0);
  endtask

  task automatic run_frame(input string nm, input opcode_t op, input pixel_t u, input int lat);
    push_frame(op, u);
    cfg_opcode = op;
    cfg_user   = u;
    start      = 1;
    cycle();
    start      = 0;
    check({nm, "_busy"}, 32'(busy), 1);
    wait_done(nm, lat);
    check({nm, "_busy_fall"}, 32'(busy), 0);
    check({nm, "_wr_left"}, 32'(exp_q.size()), 0);
    check({nm, "_rd_left"}, 32'(rd_q.size()), 0);
  endtask

  initial begin
    int wc;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        mem[y*W + x]      = pixel_t'(16*y + x);
        mem[16 + y*W + x] = 8'd3;
      end
    repeat (3) cycle();
    rst = 0;

    // Idle after reset: the monitor flags any memory traffic.
    wc = wr_count;
    repeat (20) cycle();
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_rd_en", 32'(rd_en), 0);
    check("idle_wr_en", 32'(wr_en), 0);
    check("idle_iw", 32'(IW != '0), 0);
    check("idle_writes", 32'(wr_count - wc), 0);

    wc = wr_count;
    run_frame("avg", OP_AVG, 8'd0, 177);
    check("avg_writes", 32'(wr_count - wc), 16);
    run_frame("addi", OP_ADDI, 8'd5, 177);
    run_frame("add", OP_ADD, 8'd0, 321);
    check("iw_retained", 32'(IW.opcode), 32'(OP_ADD));

    // Reset mid-frame during FETCH of pixel (2,1): pixel 6 starts 66 edges after accept.
    push_frame(OP_AVG, 8'd0);
    cfg_opcode = OP_AVG;
    wc = wr_count;
    start = 1;
    cycle();
    start = 0;
    for (int c = 1; c < 70; c++) cycle();
    check("rst_point_writes", 32'(wr_count - wc), 6);
    check("rst_point_rd_en", 32'(rd_en), 1);
    rst = 1;
    cycle();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_iw", 32'(IW != '0), 0);
    cycle();
    rst = 0;
    cycle();
    run_frame("avg_after_rst", OP_AVG, 8'd0, 177);

    // Mid-frame start with new config is ignored; start held through DONE chains a second frame.
    push_frame(OP_AVG, 8'd0);
    push_frame(OP_SUBI, 8'd7);
    cfg_opcode = OP_AVG;
    cfg_user   = 8'd0;
    start = 1;
    cycle();
    start = 0;
    for (int c = 1; c < 50; c++) cycle();
    cfg_opcode = OP_SUBI;
    cfg_user   = 8'd7;
    start = 1;
    begin
      int cyc;
      cyc = 50;
      while (!done && cyc < 1000) begin
        cycle();
        cyc++;
      end
      check("chain1_latency", 32'(cyc), 177);
    end
    cycle();
    check("chain_idle_busy", 32'(busy), 0);
    cycle();
    check("chain2_busy", 32'(busy), 1);
    start = 0;
    wait_done("chain2", 177);
    check("chain_wr_left", 32'(exp_q.size()), 0);
    check("chain_rd_left", 32'(rd_q.size()), 0);
    check("chain_iw_op", 32'(IW.opcode), 32'(OP_SUBI));

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/cell_scan_controller.md
Name: cell_scan_controller

Overview:
- Sequences the combinational CellProcessor over a whole frame.
- For every output pixel (x,y), fetches the 3x3 neighbourhood from a 1-cycle-latency frame memory. The neighbourhood comes from plane A; binary ops also fetch the same neighbourhood from plane B.
- Assembles the instruction word, drives it to CellProcessor, and writes the returned result to the output frame.
- Sits between the frame buffers and the CellProcessor; the host issues one start per frame.

Parameters:
- IMG_W, 8, frame width in pixels (>=2)
- IMG_H, 8, frame height in pixels (>=2)
- ADDR_W, $clog2(2*IMG_W*IMG_H), read address width. Write address width is ADDR_W-1.

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- cfg_opcode  in  opcode field type  operation for the frame
- cfg_user  in  userInputA field type  immediate for ADDI/SUBI
- busy  out  1  high from the cycle after start is accepted up to and including DONE
- done  out  1  one-cycle pulse in DONE
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  plane*IMG_W*IMG_H + y*IMG_W + x
- rd_data  in  pixel_t  valid the cycle after rd_en
- IW  out  instruction_t  to CellProcessor
- result  in  pixel_t  from CellProcessor, combinational
- wr_en  out  1  output-frame write strobe
- wr_addr  out  ADDR_W-1  y*IMG_W + x
- wr_data  out  pixel_t  equals result when wr_en is high

Behaviour:
- Synchronous active-high reset on clk, effective from any state including mid-frame. Reset returns the block to IDLE and sets:
  - busy, done, rd_en, wr_en = 0
  - rd_addr, wr_addr = 0
  - IW = all zero
  - x, y, k counters = 0
- In IDLE with start=1: latch cfg_opcode and cfg_user, set x=y=0, go to FETCH.
  - N = 18 if the opcode is ADD or SUB, else N = 9.
  - Config inputs are ignored while not IDLE; start is ignored while busy.
- FETCH: runs N cycles, k = 0..N-1, with rd_en=1 each cycle.
  - Plane = 0 for k<9, 1 for k>=9. j = k mod 9, row = j/3, col = j%3.
  - Coordinates: xs = clamp(x+col-1, 0, IMG_W-1), ys = clamp(y+row-1, 0, IMG_H-1). Border pixels replicate the edge.
  - rd_data returned in cycle k+1 is stored into cellA.pixelMatrix[row][col] for plane 0, or cellB.pixelMatrix[row][col] for plane 1.
  - After k=N-1, go to DRAIN.
- DRAIN: one cycle, rd_en=0, captures the last read; go to ISSUE.
- ISSUE: one cycle.
  - IW carries the latched opcode, cellA, cellB (all zero when N=9) and userInputA=cfg_user.
  - wr_en=1, wr_addr=y*IMG_W+x, wr_data=result.
  - Then advance x, wrapping to 0 and incrementing y at IMG_W-1.
  - If (x,y) was (IMG_W-1, IMG_H-1), go to DONE; otherwise go to FETCH with k=0.
- DONE: done=1 and busy=1 for one cycle, then IDLE. busy falls the cycle after done.
- IW is held stable outside ISSUE. It is zero only after reset; after a frame it retains the last value.
- Cycles per pixel = N+2. Frame length from start-accept edge to done = IMG_W*IMG_H*(N+2)+1 cycles.
- Cell storage is overwritten every pixel. No stale data is carried between pixels except the cellB zeroing rule.
- rd_en and wr_en are never high in the same cycle.

Test Plan:
- Reset, then 20 idle cycles -> busy=done=rd_en=wr_en=0, IW=0, no memory traffic.
- IMG_W=IMG_H=4, plane A pixel(x,y)=16*y+x, opcode AVG, start pulse:
  - exactly 16 writes in raster order, wr_addr 0..15;
  - each pixel reads 9 addresses, pixel (0,0) reads addresses {0,0,1,0,0,1,4,4,5};
  - done asserts 16*11+1=177 cycles after the start edge;
  - wr_data matches a package-function golden model.
- Same image, ADDI with cfg_user=5 -> 16 writes, wr_data = addi(cell,5) golden, each pixel 11 cycles, no plane-B address (>=16) ever read.
- ADD with plane B = constant 3 -> 18 reads per pixel, reads 9..17 address 16+, 20 cycles per pixel, done at 16*20+1=321 cycles.
- Assert rst during FETCH of pixel (2,1) -> next cycle IDLE, all outputs at reset values. A fresh start then re-processes from (0,0) with correct results.
- Pulse start mid-frame and change cfg_opcode -> ignored, frame completes with the original opcode. Start held high through DONE -> a second frame begins the cycle after returning to IDLE.
